block_sync_ctrl: RTL and testbench

Receive-side 64b/66b block-lock controller for the 10GBASE-R PHY. It sits between the GTX RX gearbox and `decode_64b_66b`. It watches the 2-bit sync headers, drives the gearbox slip request until headers align, and reports block lock. It also gates `decode_data_vld_i` to the decoder so that unaligned blocks never reach XGMII. An optional high-BER monitor reports a sustained invalid-header rate.

---
 rtl/block_sync_ctrl.sv | 172 +++++++++++++++++
 tb/tb_block_sync_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_sync_ctrl.sv
// 64b/66b receive block-lock controller: hunts for sync-header alignment via gearbox slips,
// reports block lock, and gates decoder valid. Optional high-BER monitor: BLOCK_SYNC_HI_BER_EN.
module block_sync_ctrl #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32,
    parameter int BER_WIN      = 31250,
    parameter int BER_THRESH   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  rx_head_i,
    input  logic        rx_head_vld_i,
    output logic        rx_slip_o,
    output logic        block_lock_o,
    output logic        decode_vld_o,
    output logic [1:0]  lock_state_o,
    output logic [15:0] slip_cnt_o,
    output logic        hi_ber_o
);

    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_SLIP   = 2'd1,
        S_WAIT   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [SH_W-1:0]    r_shCnt;
    logic [SH_W-1:0]    w_shCntNext;
    logic [SH_W-1:0]    w_shInc;
    logic [INV_W-1:0]   r_invldCnt;
    logic [INV_W-1:0]   w_invldCntNext;
    logic [INV_W-1:0]   w_invInc;
    logic [WAIT_W-1:0]  r_waitCnt;
    logic [WAIT_W-1:0]  w_waitCntNext;
    logic               r_slip;
    logic               r_lock;
    logic [15:0]        r_slipCnt;
    logic               w_headValid;

    assign w_headValid = rx_head_i[1] ^ rx_head_i[0];
    assign w_shInc     = r_shCnt + SH_W'(1);
    assign w_invInc    = r_invldCnt + INV_W'(1);

    always_comb begin
        w_nextState    = r_state;
        w_shCntNext    = r_shCnt;
        w_invldCntNext = r_invldCnt;
        w_waitCntNext  = r_waitCnt;
        unique case (r_state)
            S_HUNT: begin
                if (rx_head_vld_i) begin
                    if (!w_headValid) begin
                        w_nextState = S_SLIP;
                    end else if (w_shInc == SH_W'(SH_CNT_MAX)) begin
                        w_nextState    = S_LOCKED;
                        w_shCntNext    = '0;
                        w_invldCntNext = '0;
                    end else begin
                        w_shCntNext = w_shInc;
                    end
                end
            end
            S_SLIP: begin
                w_nextState   = S_WAIT;
                w_waitCntNext = '0;
            end
            S_WAIT: begin
                if (r_waitCnt == WAIT_W'(SLIP_WAIT - 1)) begin
                    w_nextState    = S_HUNT;
                    w_shCntNext    = '0;
                    w_invldCntNext = '0;
                    w_waitCntNext  = '0;
                end else begin
                    w_waitCntNext = r_waitCnt + WAIT_W'(1);
                end
            end
            S_LOCKED: begin
                // Loss of lock takes priority over a window that completes on the same header
                if (rx_head_vld_i) begin
                    if (!w_headValid && (w_invInc == INV_W'(SH_INVLD_MAX))) begin
                        w_nextState = S_SLIP;
                    end else if (w_shInc == SH_W'(SH_CNT_MAX)) begin
                        w_shCntNext    = '0;
                        w_invldCntNext = '0;
                    end else begin
                        w_shCntNext = w_shInc;
                        if (!w_headValid) begin
                            w_invldCntNext = w_invInc;
                        end
                    end
                end
            end
            default: w_nextState = S_HUNT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_HUNT;
            r_shCnt    <= '0;
            r_invldCnt <= '0;
            r_waitCnt  <= '0;
            r_slip     <= 1'b0;
            r_lock     <= 1'b0;
            r_slipCnt  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_shCnt    <= w_shCntNext;
            r_invldCnt <= w_invldCntNext;
            r_waitCnt  <= w_waitCntNext;
            r_slip     <= (w_nextState == S_SLIP);
            r_lock     <= (w_nextState == S_LOCKED);
            if ((w_nextState == S_SLIP) && (r_slipCnt != 16'hFFFF)) begin
                r_slipCnt <= r_slipCnt + 16'd1;
            end
        end
    end

    assign rx_slip_o    = r_slip;
    assign block_lock_o = r_lock;
    assign lock_state_o = r_state;
    assign slip_cnt_o   = r_slipCnt;
    assign decode_vld_o = rx_head_vld_i & r_lock;

`ifdef BLOCK_SYNC_HI_BER_EN
    localparam logic [14:0] BER_LAST = 15'(BER_WIN - 1);
    localparam logic [7:0]  BER_TH8  = 8'(BER_THRESH);

    logic [14:0] r_berWinCnt;
    logic [7:0]  r_berInvCnt;
    logic [7:0]  w_berInvNext;
    logic        r_hiBer;
    logic        w_lossOfLock;

    assign w_berInvNext = (!w_headValid && (r_berInvCnt != 8'hFF)) ? r_berInvCnt + 8'd1 : r_berInvCnt;
    assign w_lossOfLock = (w_nextState == S_SLIP);

    // The header closing a window is included in that window's verdict
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_berWinCnt <= '0;
            r_berInvCnt <= '0;
            r_hiBer     <= 1'b0;
        end else if ((r_state == S_LOCKED) && rx_head_vld_i) begin
            if (r_berWinCnt == BER_LAST) begin
                r_hiBer     <= (w_berInvNext >= BER_TH8);
                r_berWinCnt <= '0;
                r_berInvCnt <= '0;
            end else if (w_lossOfLock) begin
                r_berWinCnt <= '0;
                r_berInvCnt <= '0;
            end else begin
                r_berWinCnt <= r_berWinCnt + 15'd1;
                r_berInvCnt <= w_berInvNext;
            end
        end
    end

    assign hi_ber_o = r_hiBer;
`else
    assign hi_ber_o = 1'b0;
`endif

endmodule

// File: tb/tb_block_sync_ctrl.sv
// Scoreboard bench for block_sync_ctrl: a header-level reference model predicts each cycle's
// outputs into a queue, and a monitor compares them mid-cycle.
module tb_block_sync_ctrl;

   localparam int SH_CNT_MAX   = 64;
   localparam int SH_INVLD_MAX = 16;
   localparam int SLIP_WAIT    = 32;
`ifdef BLOCK_SYNC_HI_BER_EN
   localparam int BER_WIN      = 100;
`else
   localparam int BER_WIN      = 31250;
`endif
   localparam int BER_THRESH   = 16;

   localparam int M_HUNT = 0, M_SLIP = 1, M_WAIT = 2, M_LOCKED = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  head = 2'b00;
   logic        vld = 1'b0;
   logic        rxSlip, blockLock, decodeVld, hiBer;
   logic [1:0]  lockState;
   logic [15:0] slipCnt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  state;
      logic        slip;
      logic        lock;
      logic        dec;
      logic        hiBer;
      logic [15:0] slipCnt;
   } expect_t;

   expect_t expQ[$];

   // Reference model: counts headers per rule, no knowledge of the RTL structure
   int mMode, mGood, mBad, mWaitLeft, mSlips, mBerHdr, mBerBad;
   bit mHiBer;

   always #5 clk = ~clk;

   block_sync_ctrl #(
      .SH_CNT_MAX(SH_CNT_MAX), .SH_INVLD_MAX(SH_INVLD_MAX), .SLIP_WAIT(SLIP_WAIT),
      .BER_WIN(BER_WIN), .BER_THRESH(BER_THRESH)
   ) dut (
      .clk_i(clk), .rst_i(rst), .rx_head_i(head), .rx_head_vld_i(vld),
      .rx_slip_o(rxSlip), .block_lock_o(blockLock), .decode_vld_o(decodeVld),
      .lock_state_o(lockState), .slip_cnt_o(slipCnt), .hi_ber_o(hiBer)
   );

   // Model reset state
   function automatic void modelReset();
      mMode = M_HUNT; mGood = 0; mBad = 0; mWaitLeft = 0; mSlips = 0;
      mBerHdr = 0; mBerBad = 0; mHiBer = 1'b0;
   endfunction

   // Model entry into a slip
   function automatic void modelSlip();
      mMode = M_SLIP;
      if (mSlips < 65535) mSlips++;
   endfunction

   // Model advance across one clock edge
   function automatic void modelStep(bit r, bit v, logic [1:0] h);
      bit bad;
      bad = (h == 2'b00) || (h == 2'b11);
      if (r) begin
         modelReset();
         return;
      end
`ifdef BLOCK_SYNC_HI_BER_EN
      if (mMode == M_LOCKED && v) begin
         mBerHdr++;
         if (bad && mBerBad < 255) mBerBad++;
         if (mBerHdr == BER_WIN) begin
            mHiBer = (mBerBad >= BER_THRESH);
            mBerHdr = 0; mBerBad = 0;
         end
      end
`endif
      case (mMode)
         M_HUNT: if (v) begin
            if (bad) modelSlip();
            else begin
               mGood++;
               if (mGood == SH_CNT_MAX) begin mMode = M_LOCKED; mGood = 0; mBad = 0; end
            end
         end
         M_SLIP: begin mMode = M_WAIT; mWaitLeft = SLIP_WAIT; end
         M_WAIT: begin
            mWaitLeft--;
            if (mWaitLeft == 0) begin mMode = M_HUNT; mGood = 0; mBad = 0; end
         end
         default: if (v) begin
            mGood++;
            if (bad) mBad++;
            if (mBad == SH_INVLD_MAX) begin
               modelSlip();
               mBerHdr = 0; mBerBad = 0;
            end else if (mGood == SH_CNT_MAX) begin
               mGood = 0; mBad = 0;
            end
         end
      endcase
   endfunction

   // Drive one cycle of inputs, predict that cycle's outputs, then advance the model
   task automatic applyStimulus(bit r, bit v, logic [1:0] h);
      expect_t e;
      @(posedge clk);
      #1;
      rst = r; vld = v; head = h;
      e.state   = 2'(mMode);
      e.slip    = (mMode == M_SLIP);
      e.lock    = (mMode == M_LOCKED);
      e.dec     = v && (mMode == M_LOCKED);
      e.hiBer   = mHiBer;
      e.slipCnt = 16'(mSlips);
      expQ.push_back(e);
      modelStep(r, v, h);
   endtask

   task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: every mid-cycle with a pending prediction is compared
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("lock_state", 16'(lockState), 16'(e.state));
            checkOutput("rx_slip", 16'(rxSlip), 16'(e.slip));
            checkOutput("block_lock", 16'(blockLock), 16'(e.lock));
            checkOutput("decode_vld", 16'(decodeVld), 16'(e.dec));
            checkOutput("hi_ber", 16'(hiBer), 16'(e.hiBer));
            checkOutput("slip_cnt", slipCnt, e.slipCnt);
         end
      end
   end

   function automatic logic [1:0] goodHead();
      return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [1:0] badHead();
      return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
   endfunction

   task automatic resetDut();
      repeat (3) applyStimulus(1'b1, 1'b0, 2'b00);
   endtask

   task automatic sendGood(int n, bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, badHead());
         applyStimulus(1'b0, 1'b1, goodHead());
      end
   endtask

   // n strobed headers with nBad invalid ones scattered; lastBad forces the final one invalid
   task automatic sendWindow(int n, int nBad, bit lastBad, bit gaps);
      bit flags[$];
      int m;
      bit t;
      int j;
      m = lastBad ? n - 1 : n;
      for (int i = 0; i < m; i++) flags.push_back(i < nBad);
      for (int i = m - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = flags[i]; flags[i] = flags[j]; flags[j] = t;
      end
      if (lastBad) flags.push_back(1'b1);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 4) == 0) applyStimulus(1'b0, 1'b0, goodHead());
         applyStimulus(1'b0, 1'b1, flags[i] ? badHead() : goodHead());
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, badHead());
   endtask

   initial begin
      int badRate;
      bit v;
      modelReset();

      $display("[TB] clean lock");
      resetDut();
      for (int i = 0; i < SH_CNT_MAX; i++) applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
      idle(2);
      sendGood(10, 1'b1);

      $display("[TB] locked tolerance");
      resetDut();
      sendGood(SH_CNT_MAX, 1'b0);
      sendWindow(SH_CNT_MAX, SH_INVLD_MAX - 1, 1'b0, 1'b1);
      sendWindow(SH_CNT_MAX, SH_INVLD_MAX, 1'b0, 1'b1);
      idle(SLIP_WAIT + 4);

      $display("[TB] simultaneous window end and loss of lock");
      resetDut();
      sendGood(SH_CNT_MAX, 1'b1);
      sendWindow(SH_CNT_MAX, SH_INVLD_MAX - 1, 1'b1, 1'b0);
      idle(SLIP_WAIT + 4);

      $display("[TB] hunt slip");
      resetDut();
      sendGood(9, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'b00);
      for (int i = 0; i < SLIP_WAIT + 1; i++) applyStimulus(1'b0, 1'b1, 2'b11);
      sendGood(SH_CNT_MAX + 4, 1'b0);

      $display("[TB] reset mid-wait");
      resetDut();
      sendGood(3, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'b11);
      applyStimulus(1'b0, 1'b1, 2'b01);
      repeat (4) applyStimulus(1'b0, 1'b1, 2'b01);
      applyStimulus(1'b1, 1'b1, 2'b01);
      sendGood(SLIP_WAIT + 4, 1'b1);

`ifdef BLOCK_SYNC_HI_BER_EN
      $display("[TB] hi-ber windows");
      resetDut();
      sendGood(SH_CNT_MAX, 1'b0);
      for (int i = 0; i < BER_WIN; i++) applyStimulus(1'b0, 1'b1, (i % 6 == 0 && i < 96) ? badHead() : goodHead());
      for (int i = 0; i < BER_WIN; i++) applyStimulus(1'b0, 1'b1, (i % 30 == 7) ? badHead() : goodHead());
      idle(3);
`endif

      $display("[TB] random soak");
      resetDut();
      for (int p = 0; p < 16; p++) begin
         badRate = (p % 3 == 0) ? 5 : ((p % 3 == 1) ? 60 : 1000);
         for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(($urandom_range(0, 999) == 0), v,
                          ($urandom_range(0, badRate - 1) == 0) ? badHead() : goodHead());
         end
      end

      @(negedge clk);
      #1;
      checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
